rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter_if.sv | 26 ++
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Bundles the write-back, MDU and register-file write-port signals of rf_write_arbiter.
// The master side is the pipeline/MDU environment; the slave side is the arbiter itself.
interface rf_write_arbiter_if;
    logic        regWriteWb;
    logic [4:0]  writeRegWb;
    logic [31:0] resultWb;
    logic        mduValid;
    logic [4:0]  mduReg;
    logic [31:0] mduData;
    logic        mduReady;
    logic        rfWe;
    logic [4:0]  rfWa;
    logic [31:0] rfWd;
    logic        stallReq;
    logic [31:0] pendBusy;

    modport master (
        output regWriteWb, writeRegWb, resultWb, mduValid, mduReg, mduData,
        input  mduReady, rfWe, rfWa, rfWd, stallReq, pendBusy
    );

    modport slave (
        input  regWriteWb, writeRegWb, resultWb, mduValid, mduReg, mduData,
        output mduReady, rfWe, rfWa, rfWd, stallReq, pendBusy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between write-back and an in-order MDU result queue.
// Write-back wins unless the queue head starves long enough to force a pipeline stall.
module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0] liveQ, liveD;
    logic [4:0]       regQ  [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [PtrW-1:0]  rdPtrQ, wrPtrQ;
    logic [CntW-1:0]  countQ, countD;
    logic [StarveW-1:0] starveQ, starveD;
    logic             stallQ, stallD;

    logic        headLive, headOcc, wbReq, readyInt, push, pop;
    logic [31:0] pendVec;

    always_comb begin
        headOcc  = (countQ != '0);
        headLive = liveQ[rdPtrQ];
        wbReq    = bus.regWriteWb && (bus.writeRegWb != 5'd0) && !stallQ;
        readyInt = (countQ != CntW'(DEPTH));
        // Transfers to $0 complete the handshake but never occupy a slot.
        push     = bus.mduValid && readyInt && (bus.mduReg != 5'd0);
        // Dead heads pop unconditionally; live heads only when write-back is idle.
        pop      = headOcc && (!headLive || !wbReq);
        countD   = countQ + CntW'(push) - CntW'(pop);

        liveD = liveQ;
        for (int i = 0; i < DEPTH; i++) begin
            if (wbReq && (regQ[i] == bus.writeRegWb)) liveD[i] = 1'b0;
        end
        if (pop) liveD[rdPtrQ] = 1'b0;
        if (push) liveD[wrPtrQ] = !(wbReq && (bus.writeRegWb == bus.mduReg));

        starveD = '0;
        if (headOcc && headLive && wbReq) begin
            starveD = (starveQ == StarveW'(STARVE_LIMIT)) ? starveQ : starveQ + StarveW'(1);
        end

        stallD = stallQ;
        if (starveD == StarveW'(STARVE_LIMIT)) stallD = 1'b1;
        else if (!headOcc) stallD = 1'b0;
    end

    always_comb begin
        bus.rfWe = 1'b0;
        bus.rfWa = 5'd0;
        bus.rfWd = 32'd0;
        if (!reset) begin
            if (wbReq) begin
                bus.rfWe = 1'b1;
                bus.rfWa = bus.writeRegWb;
                bus.rfWd = bus.resultWb;
            end else if (headOcc && headLive) begin
                bus.rfWe = 1'b1;
                bus.rfWa = regQ[rdPtrQ];
                bus.rfWd = dataQ[rdPtrQ];
            end
        end

        // Live bits are cleared on pop, so live alone implies occupied.
        pendVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (liveQ[i]) pendVec[regQ[i]] = 1'b1;
        end
        pendVec[0] = 1'b0;

        bus.pendBusy = reset ? 32'd0 : pendVec;
        bus.mduReady = reset || readyInt;
        bus.stallReq = stallQ && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            liveQ   <= '0;
            rdPtrQ  <= '0;
            wrPtrQ  <= '0;
            countQ  <= '0;
            starveQ <= '0;
            stallQ  <= 1'b0;
        end else begin
            liveQ   <= liveD;
            rdPtrQ  <= pop ? rdPtrQ + PtrW'(1) : rdPtrQ;
            wrPtrQ  <= push ? wrPtrQ + PtrW'(1) : wrPtrQ;
            countQ  <= countD;
            starveQ <= starveD;
            stallQ  <= stallD;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            regQ[wrPtrQ]  <= bus.mduReg;
            dataQ[wrPtrQ] <= bus.mduData;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: MDU results go through a scoreboard queue,
// write-back and status outputs are compared against constants derived from the stimulus.
module tb_rf_write_arbiter;
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } sbEntry_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    sbEntry_t sb[$];
    logic [31:0] shadow [32];

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .DEPTH(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.rfWe) shadow[bus.rfWa] <= bus.rfWd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setWb(input logic we, input logic [4:0] r, input logic [31:0] d);
        bus.regWriteWb = we;
        bus.writeRegWb = r;
        bus.resultWb   = d;
    endtask

    task automatic setMdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mduValid = v;
        bus.mduReg   = r;
        bus.mduData  = d;
    endtask

    // Check readiness; queue the offered result when it is expected to land in the RF.
    task automatic offer(input string tag, input logic expReady, input logic keep);
        chk({tag, ".ready"}, 64'(bus.mduReady), 64'(expReady));
        if (expReady && keep && bus.mduReg != 5'd0) sb.push_back({bus.mduReg, bus.mduData});
    endtask

    task automatic expectWb(input string tag, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".we"}, 64'(bus.rfWe), 64'd1);
        chk({tag, ".wa"}, 64'(bus.rfWa), 64'(r));
        chk({tag, ".wd"}, 64'(bus.rfWd), 64'(d));
    endtask

    task automatic expectMdu(input string tag);
        sbEntry_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected a queued result", tag);
        end else begin
            e = sb.pop_front();
            expectWb(tag, e.r, e.d);
        end
    endtask

    task automatic expectIdle(input string tag);
        chk({tag, ".we"}, 64'(bus.rfWe), 64'd0);
        chk({tag, ".wa"}, 64'(bus.rfWa), 64'd0);
        chk({tag, ".wd"}, 64'(bus.rfWd), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        setWb(1'b0, 5'd0, 32'd0);
        setMdu(1'b0, 5'd0, 32'd0);
        tick();
        half();
        chk("rst.during.stall", 64'(bus.stallReq), 64'd0);
        chk("rst.during.we", 64'(bus.rfWe), 64'd0);
        tick();
        reset = 1'b0;
        half();
        chk("rst.ready", 64'(bus.mduReady), 64'd1);
        expectIdle("rst.idle");
        chk("rst.stall", 64'(bus.stallReq), 64'd0);
        chk("rst.pend", 64'(bus.pendBusy), 64'd0);
        tick();

        // Idle port: MDU result drains the cycle after enqueue.
        setMdu(1'b1, 5'd5, 32'hDEADBEEF);
        half();
        offer("idle", 1'b1, 1'b1);
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        half();
        expectMdu("idle.drain");
        chk("idle.pend", 64'(bus.pendBusy), 64'(32'h1 << 5));
        tick();
        half();
        expectIdle("idle.after");
        chk("idle.pendClr", 64'(bus.pendBusy), 64'd0);
        tick();

        // Priority: write-back wins for two cycles, then the queued result drains.
        setMdu(1'b1, 5'd7, 32'h11);
        half();
        offer("prio", 1'b1, 1'b1);
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        setWb(1'b1, 5'd3, 32'h22);
        half();
        expectWb("prio.c1", 5'd3, 32'h22);
        chk("prio.pend", 64'(bus.pendBusy), 64'(32'h1 << 7));
        tick();
        half();
        expectWb("prio.c2", 5'd3, 32'h22);
        tick();
        setWb(1'b0, 5'd0, 32'd0);
        half();
        expectMdu("prio.c3");
        tick();
        half();
        expectIdle("prio.after");
        tick();

        // WAW squash: newer write-back kills the queued write to the same register.
        setMdu(1'b1, 5'd9, 32'hAA);
        half();
        offer("waw", 1'b1, 1'b0);
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        setWb(1'b1, 5'd9, 32'hBB);
        half();
        expectWb("waw.wb", 5'd9, 32'hBB);
        chk("waw.pendSet", 64'(bus.pendBusy), 64'(32'h1 << 9));
        tick();
        setWb(1'b0, 5'd0, 32'd0);
        half();
        expectIdle("waw.deadPop");
        chk("waw.pendClr", 64'(bus.pendBusy), 64'd0);
        tick();
        half();
        chk("waw.reg9", 64'(shadow[9]), 64'hBB);
        expectIdle("waw.after");
        tick();

        // Starvation: four losing cycles raise stallReq, the head drains, stall releases.
        setMdu(1'b1, 5'd12, 32'h00C0FFEE);
        half();
        offer("starve", 1'b1, 1'b1);
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            setWb(1'b1, 5'd4, 32'h100 + 32'(k));
            half();
            expectWb("starve.lose", 5'd4, 32'h100 + 32'(k));
            chk("starve.noStall", 64'(bus.stallReq), 64'd0);
            tick();
        end
        half();
        chk("starve.stallSet", 64'(bus.stallReq), 64'd1);
        expectMdu("starve.drain");
        tick();
        half();
        chk("starve.stallHold", 64'(bus.stallReq), 64'd1);
        expectIdle("starve.wbIgnored");
        tick();
        half();
        chk("starve.stallClr", 64'(bus.stallReq), 64'd0);
        expectWb("starve.wbResume", 5'd4, 32'h103);
        tick();
        setWb(1'b0, 5'd0, 32'd0);

        // Full queue / backpressure with write-back busy.
        setWb(1'b1, 5'd2, 32'h55);
        setMdu(1'b1, 5'd10, 32'hA0);
        half();
        offer("full.a", 1'b1, 1'b1);
        expectWb("full.wb1", 5'd2, 32'h55);
        tick();
        setMdu(1'b1, 5'd11, 32'hB0);
        half();
        offer("full.b", 1'b1, 1'b1);
        expectWb("full.wb2", 5'd2, 32'h55);
        tick();
        setMdu(1'b1, 5'd13, 32'hC0);
        half();
        offer("full.cHeld1", 1'b0, 1'b1);
        expectWb("full.wb3", 5'd2, 32'h55);
        tick();
        half();
        offer("full.cHeld2", 1'b0, 1'b1);
        expectWb("full.wb4", 5'd2, 32'h55);
        chk("full.pend", 64'(bus.pendBusy), 64'((32'h1 << 10) | (32'h1 << 11)));
        tick();
        setWb(1'b0, 5'd0, 32'd0);
        half();
        offer("full.popNoOpen", 1'b0, 1'b1);
        expectMdu("full.drainA");
        tick();
        half();
        offer("full.c", 1'b1, 1'b1);
        expectMdu("full.drainB");
        tick();
        setMdu(1'b1, 5'd0, 32'hFFFFFFFF);
        half();
        offer("full.zero", 1'b1, 1'b1);
        expectMdu("full.drainC");
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        half();
        expectIdle("full.zeroDropped");
        chk("full.pendClr", 64'(bus.pendBusy), 64'd0);
        tick();

        // Reset mid-operation with a full queue and stall asserted.
        setWb(1'b1, 5'd6, 32'h66);
        setMdu(1'b1, 5'd14, 32'hE0);
        half();
        offer("rst2.d", 1'b1, 1'b1);
        tick();
        setMdu(1'b1, 5'd15, 32'hF0);
        half();
        offer("rst2.e", 1'b1, 1'b1);
        tick();
        setMdu(1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            half();
            chk("rst2.noStall", 64'(bus.stallReq), 64'd0);
            expectWb("rst2.wb", 5'd6, 32'h66);
            tick();
        end
        half();
        chk("rst2.stall", 64'(bus.stallReq), 64'd1);
        chk("rst2.full", 64'(bus.mduReady), 64'd0);
        expectMdu("rst2.drainD");
        tick();
        reset = 1'b1;
        half();
        chk("rst2.during.we", 64'(bus.rfWe), 64'd0);
        tick();
        reset = 1'b0;
        setWb(1'b0, 5'd0, 32'd0);
        sb.delete();
        half();
        chk("rst2.ready", 64'(bus.mduReady), 64'd1);
        chk("rst2.stallClr", 64'(bus.stallReq), 64'd0);
        chk("rst2.pend", 64'(bus.pendBusy), 64'd0);
        expectIdle("rst2.idle");
        tick();
        half();
        expectIdle("rst2.discarded");
        tick();

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
